wave_capture: RTL and testbench

// - Writer side of the double-buffered 512x8 waveform RAM that wave_display reads.
// - Watches the audio sample stream, triggers on a rising zero crossing and writes 256

---
 rtl/wave_capture_if.sv | 34 +++
 rtl/wave_capture.sv | 117 +++++++++++
 tb/tb_wave_capture.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wave_capture_if.sv
// wave_capture_if: sample-stream input, display handshake and waveform RAM write port
// of the wave_capture block. The slave modport is the capture block itself; the master
// modport is whatever feeds samples and consumes the RAM writes.
interface wave_capture_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                           new_sample_ready;
    logic signed [SAMPLE_WIDTH-1:0] new_sample_in;
    logic                           wave_display_idle;
    logic [8:0]                     write_address;
    logic                           write_enable;
    logic [7:0]                     write_sample;
    logic                           read_index;

    modport master (
        output new_sample_ready,
        output new_sample_in,
        output wave_display_idle,
        input  write_address,
        input  write_enable,
        input  write_sample,
        input  read_index
    );

    modport slave (
        input  new_sample_ready,
        input  new_sample_in,
        input  wave_display_idle,
        output write_address,
        output write_enable,
        output write_sample,
        output read_index
    );
endinterface

// File: rtl/wave_capture.sv
// wave_capture: writer side of the double-buffered 512x8 waveform RAM.
// Arms on reset, triggers on a rising zero crossing of the sample stream, writes 256
// samples into the half not owned by the display, then waits for the display to go
// idle before handing the freshly written half over by flipping read_index.
// Optional build macro WAVE_CAPTURE_DECIMATE_EN: while capturing, only every
// 2**DECIM_LOG2-th strobe is written, so one buffer spans a longer stretch of audio.
module wave_capture #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DECIM_LOG2   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    wave_capture_if.slave bus
);
    localparam int MSB = SAMPLE_WIDTH - 1;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Signed sample to 8-bit offset binary: flip the sign bit, keep the top magnitude bits.
    function automatic logic [7:0] to_offset_binary(input logic signed [SAMPLE_WIDTH-1:0] s);
        return {~s[MSB], s[MSB-1 -: 7]};
    endfunction

    state_t     state;
    logic [7:0] index;
    logic       prev_neg;
    logic       strobe;
    logic       sample_neg;
    logic       rising_cross;
    logic       take;

    assign strobe       = bus.new_sample_ready;
    assign sample_neg   = bus.new_sample_in[MSB];
    assign rising_cross = strobe & prev_neg & ~sample_neg;

`ifdef WAVE_CAPTURE_DECIMATE_EN
    // Strobes since the last written sample; a write is taken when it rolls over to 0.
    logic [DECIM_LOG2-1:0] decim;
    logic [DECIM_LOG2-1:0] decim_next;
    assign decim_next = decim + 1'b1;
    assign take       = (decim_next == '0);
`else
    localparam int unused_decim_log2 = DECIM_LOG2;
    assign take = 1'b1;
`endif

    // Sample bits below the top eight never reach the RAM.
    if (SAMPLE_WIDTH > 8) begin : g_low_bits
        logic unused_low_bits;
        assign unused_low_bits = ^bus.new_sample_in[SAMPLE_WIDTH-9:0];
    end

    // Capture FSM with registered RAM write port and buffer ownership bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ARMED;
            index             <= '0;
            prev_neg          <= 1'b0;
            bus.read_index    <= 1'b0;
            bus.write_enable  <= 1'b0;
            bus.write_address <= '0;
            bus.write_sample  <= '0;
`ifdef WAVE_CAPTURE_DECIMATE_EN
            decim             <= '0;
`endif
        end else begin
            bus.write_enable <= 1'b0;
            if (strobe) begin
                prev_neg <= sample_neg;
            end
            case (state)
                ARMED: begin
                    if (rising_cross) begin
                        bus.write_enable  <= 1'b1;
                        bus.write_address <= {~bus.read_index, 8'd0};
                        bus.write_sample  <= to_offset_binary(bus.new_sample_in);
                        index             <= 8'd1;
                        state             <= ACTIVE;
`ifdef WAVE_CAPTURE_DECIMATE_EN
                        decim             <= '0;
`endif
                    end
                end
                ACTIVE: begin
                    if (strobe) begin
`ifdef WAVE_CAPTURE_DECIMATE_EN
                        decim <= decim_next;
`endif
                        if (take) begin
                            bus.write_enable  <= 1'b1;
                            bus.write_address <= {~bus.read_index, index};
                            bus.write_sample  <= to_offset_binary(bus.new_sample_in);
                            index             <= index + 8'd1;
                            if (index == 8'hFF) begin
                                state <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    // Strobes are dropped here; the display takes the new half once idle.
                    if (bus.wave_display_idle) begin
                        bus.read_index <= ~bus.read_index;
                        state          <= ARMED;
                    end
                end
                default: begin
                    state <= ARMED;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: randomized and directed stimulus for wave_capture with a scoreboard.
// The driver updates a buffer-level reference model and queues each expected RAM write;
// an independent monitor pops and compares whenever the DUT raises write_enable.
module tb_wave_capture;
    localparam int SW  = 16;
    localparam int DL2 = 1;
`ifdef WAVE_CAPTURE_DECIMATE_EN
    localparam int STEP = 1 << DL2;
`else
    localparam int STEP = 1;
`endif

    logic clk = 1'b0;
    logic reset_n;

    wave_capture_if #(.SAMPLE_WIDTH(SW)) bus ();

    wave_capture #(
        .SAMPLE_WIDTH(SW),
        .DECIM_LOG2  (DL2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues of expected RAM writes
    int exp_addr[$];
    int exp_data[$];

    // Reference model: which half the display owns, how many samples of the current
    // buffer are stored (-1 = waiting for a crossing, 256 = buffer complete),
    // strobes seen since the trigger, and the sign of the last strobed sample.
    int m_half;
    int m_fill;
    int m_since;
    bit m_prev_neg;

    int         wr_count  = 0;
    logic [8:0] last_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_half     = 0;
        m_fill     = -1;
        m_since    = 0;
        m_prev_neg = 1'b0;
        exp_addr.delete();
        exp_data.delete();
    endfunction

    function automatic void model_store(input int s);
        exp_addr.push_back((1 - m_half) * 256 + m_fill);
        exp_data.push_back(((s + 32768) >> 8) & 255);
        m_fill++;
    endfunction

    function automatic void model_cycle(input bit stb, input int s, input bit idle);
        if (m_fill == 256) begin
            if (idle) begin
                m_half = 1 - m_half;
                m_fill = -1;
            end
        end else if (stb) begin
            if (m_fill < 0) begin
                if (m_prev_neg && s >= 0) begin
                    m_fill  = 0;
                    m_since = 0;
                    model_store(s);
                end
            end else begin
                m_since++;
                if (m_since % STEP == 0) model_store(s);
            end
        end
        if (stb) m_prev_neg = (s < 0);
    endfunction

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cycle(input bit stb, input int s, input bit idle);
        bus.new_sample_ready  = stb;
        bus.new_sample_in     = 16'(s);
        bus.wave_display_idle = idle;
        model_cycle(stb, s, idle);
        @(posedge clk);
        #1;
        check("read_index", {31'd0, bus.read_index}, m_half);
        bus.new_sample_ready  = 1'b0;
        bus.wave_display_idle = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_write_enable", {31'd0, bus.write_enable}, 0);
        check("rst_write_address", {23'd0, bus.write_address}, 0);
        check("rst_write_sample", {24'd0, bus.write_sample}, 0);
        check("rst_read_index", {31'd0, bus.read_index}, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.write_enable === 1'b1) begin
            wr_count++;
            last_addr = bus.write_address;
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write at %0t",
                         bus.write_address, bus.write_sample, $time);
            end else begin
                check("write_address", {23'd0, bus.write_address}, exp_addr.pop_front());
                check("write_sample", {24'd0, bus.write_sample}, exp_data.pop_front());
            end
        end
    end

    initial begin
        int base;
        bus.new_sample_ready  = 1'b0;
        bus.new_sample_in     = '0;
        bus.wave_display_idle = 1'b0;
        model_reset();
        do_reset();

        // Trigger: a positive first sample never triggers; -100 then +50 does.
        cycle(1, 50, 0);
        cycle(1, -100, 0);
        cycle(0, 0, 0);
        base = wr_count;
        cycle(1, 50, 0);
        check("trig_write_enable", {31'd0, bus.write_enable}, 1);
        check("trig_write_address", {23'd0, bus.write_address}, 9'h100);
        check("trig_write_sample", {24'd0, bus.write_sample}, 8'h80);

        // Fill with a ramp and random gaps, then extra strobes that must be dropped.
        for (int i = 1; i <= 255 * STEP + 20; i++) begin
            if ($urandom_range(0, 3) == 0) cycle(0, 0, 0);
            cycle(1, -20000 + i * 64, 0);
        end
        cycle(0, 0, 0);
        check("fill_count", wr_count - base, 256);
        check("fill_last_addr", {23'd0, last_addr}, 9'h1FF);
        check("hold_read_index", {31'd0, bus.read_index}, 0);

        // Flip with a strobe in the same cycle: strobe dropped, flip taken.
        cycle(1, -5, 1);
        check("flip1_read_index", {31'd0, bus.read_index}, 1);

        // Partial capture into half 0, then reset mid-capture.
        cycle(1, 400, 0);
        for (int i = 0; i < 99 * STEP; i++) cycle(1, $urandom_range(0, 65535) - 32768, 0);
        do_reset();

        // After reset only a fresh crossing restarts; positive samples alone do nothing.
        base = wr_count;
        for (int i = 0; i < 10; i++) cycle(1, 100 + i, 0);
        check("no_write_after_reset", wr_count - base, 0);
        cycle(1, -1, 0);
        cycle(1, 0, 0);
        check("restart_write_enable", {31'd0, bus.write_enable}, 1);
        check("restart_write_address", {23'd0, bus.write_address}, 9'h100);

        // Back-to-back: trigger + 510 strobes always fill exactly one buffer.
        for (int i = 0; i < 510; i++) cycle(1, $urandom_range(0, 65535) - 32768, 0);
        cycle(0, 0, 0);
        check("b2b_count", wr_count - base, 256);
        check("b2b_last_addr", {23'd0, last_addr}, 9'h1FF);

        // Idle held high for several cycles flips exactly once.
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(1, -7, 1);
        check("flip2_read_index", {31'd0, bus.read_index}, 1);

        // Second capture lands in the lower half, then flips back.
        base = wr_count;
        cycle(1, 7, 0);
        for (int i = 0; i < 255 * STEP; i++) cycle(1, $urandom_range(0, 65535) - 32768, 0);
        cycle(0, 0, 0);
        check("low_count", wr_count - base, 256);
        check("low_last_addr", {23'd0, last_addr}, 9'h0FF);
        cycle(0, 0, 1);
        check("flip3_read_index", {31'd0, bus.read_index}, 0);

        // Random traffic: strobes, signs and idle pulses all random.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 65535) - 32768,
                  $urandom_range(0, 15) == 0);
        end

        // Drain: every expected write must have appeared.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        check("queue_empty", exp_addr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
